// File: rtl/sensor_frame_tx.sv
// Frames NUM_CH parallel sensor samples into a byte stream for a UART transmitter:
// SYNC, SEQ, channel bytes (ch0 first, LSB first), CHECKSUM, with a valid/ready handshake.
module sensor_frame_tx #(
   parameter int unsigned NUM_CH        = 3,
   parameter int unsigned CH_WIDTH      = 16,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int unsigned PERIOD_CYCLES = 1000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
   input  logic                       enable,
   input  logic                       trigger,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       overrun
);
   localparam int unsigned DW = NUM_CH * CH_WIDTH;
   localparam int unsigned NB = DW / 8;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEQ, ST_DATA, ST_CSUM} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   idx_reg, idx_next;
   logic [7:0]      csum_reg, csum_next;
   logic [7:0]      seq_reg, seq_next;
   logic [DW-1:0]   snap_reg, snap_next;
   logic            done_reg, done_next;
   logic            overrun_reg, overrun_next;
   logic            tick;
   logic            start_req;
   logic            accept;
   logic [7:0]      snap_bytes [NB];

   // Period timer: counts only while enabled, keeps running during a frame.
   generate
      if (PERIOD_CYCLES > 0) begin : g_timer
         localparam int unsigned TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
         localparam logic [TW-1:0] TICK_VAL = TW'(PERIOD_CYCLES - 1);
         logic [TW-1:0] timer_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               timer_reg <= '0;
            end else if (!enable || (timer_reg == TICK_VAL)) begin
               timer_reg <= '0;
            end else begin
               timer_reg <= timer_reg + TW'(1);
            end
         end

         assign tick = (timer_reg == TICK_VAL);
      end else begin : g_no_timer
         assign tick = 1'b0;
      end
   endgenerate

   for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
      assign snap_bytes[gi] = snap_reg[8*gi +: 8];
   end

   assign start_req  = enable && (trigger || tick);
   assign tx_valid   = (state_reg != ST_IDLE);
   assign busy       = (state_reg != ST_IDLE);
   assign accept     = tx_valid && tx_ready;
   assign frame_done = done_reg;
   assign overrun    = overrun_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         csum_reg    <= 8'h00;
         seq_reg     <= 8'h00;
         snap_reg    <= '0;
         done_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         csum_reg    <= csum_next;
         seq_reg     <= seq_next;
         snap_reg    <= snap_next;
         done_reg    <= done_next;
         overrun_reg <= overrun_next;
      end
   end

   // tx_data is decoded from registered state only, so it holds while stalled.
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      csum_next    = csum_reg;
      seq_next     = seq_reg;
      snap_next    = snap_reg;
      done_next    = 1'b0;
      overrun_next = start_req && (state_reg != ST_IDLE);
      tx_data      = 8'h00;
      case (state_reg)
         ST_IDLE: begin
            if (start_req) begin
               // checksum starts from SEQ so only data bytes are added later
               snap_next  = ch_data;
               csum_next  = seq_reg;
               idx_next   = '0;
               state_next = ST_SYNC;
            end
         end
         ST_SYNC: begin
            tx_data = SYNC_BYTE;
            if (accept) state_next = ST_SEQ;
         end
         ST_SEQ: begin
            tx_data = seq_reg;
            if (accept) state_next = ST_DATA;
         end
         ST_DATA: begin
            tx_data = snap_bytes[idx_reg];
            if (accept) begin
               csum_next = csum_reg + snap_bytes[idx_reg];
               if (idx_reg == LAST_IDX) begin
                  state_next = ST_CSUM;
               end else begin
                  idx_next = idx_reg + IW'(1);
               end
            end
         end
         ST_CSUM: begin
            tx_data = csum_reg;
            if (accept) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
               seq_next   = seq_reg + 8'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Scoreboard bench for sensor_frame_tx: expected frames are queued at trigger time and
// popped as the DUT hands bytes over; a second instance exercises the period timer.
module tb_sensor_frame_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [47:0] ch_data;
   logic        enable, trigger, tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid, busy, frame_done, overrun;

   logic        p_enable, p_trigger, p_tx_ready;
   logic [7:0]  p_tx_data;
   logic        p_tx_valid, p_busy, p_frame_done, p_overrun;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  tb_seq;
   int          done_cnt = 0, ovr_cnt = 0, exp_done = 0, exp_ovr = 0;

   sensor_frame_tx #(.NUM_CH(3), .CH_WIDTH(16), .SYNC_BYTE(8'hA5), .PERIOD_CYCLES(0)) dut (
      .clk(clk), .reset(reset), .ch_data(ch_data), .enable(enable), .trigger(trigger),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   sensor_frame_tx #(.NUM_CH(3), .CH_WIDTH(16), .SYNC_BYTE(8'hA5), .PERIOD_CYCLES(50)) dut_p (
      .clk(clk), .reset(reset), .ch_data(ch_data), .enable(p_enable), .trigger(p_trigger),
      .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready), .busy(p_busy),
      .frame_done(p_frame_done), .overrun(p_overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input logic [47:0] d, input logic [7:0] s);
      logic [7:0] sum;
      sum = s;
      exp_q.push_back(8'hA5);
      exp_q.push_back(s);
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back(d[8*k +: 8]);
         sum = sum + d[8*k +: 8];
      end
      exp_q.push_back(sum);
   endtask

   task automatic monitor();
      logic       prev_stall;
      logic [7:0] prev_data;
      logic [7:0] exp_byte;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (prev_stall) begin
               check("hold_valid", tx_valid, 1);
               check("hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
               check("sb_avail", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  exp_byte = exp_q.pop_front();
                  check("byte", tx_data, exp_byte);
                  $display("byte %02h expected %02h", tx_data, exp_byte);
               end
            end
            if (frame_done) done_cnt++;
            if (overrun) ovr_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end else begin
            prev_stall = 1'b0;
         end
      end
   endtask

   task automatic run_frame(input logic [47:0] d, input bit rnd, input int retrig);
      int n;
      ch_data = d;
      trigger = 1'b1;
      push_frame(d, tb_seq);
      tb_seq = tb_seq + 8'd1;
      exp_done++;
      if (retrig > 0) exp_ovr++;
      @(posedge clk); #1;
      trigger = 1'b0;
      n = 0;
      while (busy && n < 2000) begin
         trigger = (retrig > 0) && (n == retrig);
         if (rnd) begin
            ch_data  = {16'($urandom), 32'($urandom)};
            tx_ready = 1'($urandom);
            enable   = 1'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      trigger  = 1'b0;
      tx_ready = 1'b1;
      enable   = 1'b1;
      check("frame_end", n < 2000, 1);
      @(negedge clk);
      @(negedge clk);
      check("done_cnt", done_cnt, exp_done);
      check("ovr_cnt", ovr_cnt, exp_ovr);
      check("busy_idle", busy, 0);
      check("sb_empty", exp_q.size(), 0);
   endtask

   task automatic period_window(input int cycles, input int base, output int nrise,
                                output int ndone);
      logic prev_b;
      prev_b = p_busy;
      nrise  = 0;
      ndone  = 0;
      for (int k = 1; k <= cycles; k++) begin
         @(posedge clk); #1;
         if (p_frame_done) ndone++;
         if (p_busy && !prev_b) begin
            nrise++;
            check("p_start_cycle", k, base * nrise);
            check("p_sync", p_tx_data, 8'hA5);
         end
         check("p_overrun", p_overrun, 0);
         prev_b = p_busy;
      end
   endtask

   initial begin
      int nr, nd, total_done;
      reset      = 1'b0;
      ch_data    = '0;
      enable     = 1'b0;
      trigger    = 1'b0;
      tx_ready   = 1'b1;
      p_enable   = 1'b0;
      p_trigger  = 1'b0;
      p_tx_ready = 1'b1;
      tb_seq     = 8'h00;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      check("rst_valid", tx_valid, 0);
      check("rst_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      @(posedge clk); #1;
      reset  = 1'b1;
      enable = 1'b1;
      @(posedge clk); #1;

      run_frame(48'h0003_0002_0001, 1'b0, 0);
      run_frame(48'h0003_0002_0001, 1'b0, 0);
      for (int i = 2; i < 256; i++) run_frame({16'(i), 16'(i * 7), 16'(i * 3)}, 1'b0, 0);
      run_frame(48'hFFFF_FFFF_FFFF, 1'b0, 0);

      run_frame(48'h1234_5678_9ABC, 1'b0, 3);
      run_frame(48'h0F0F_F0F0_55AA, 1'b0, 8);
      for (int i = 0; i < 4; i++) run_frame({16'($urandom), 32'($urandom)}, 1'b1, 0);

      ch_data = 48'hDEAD_BEEF_CAFE;
      trigger = 1'b1;
      push_frame(ch_data, tb_seq);
      @(posedge clk); #1;
      trigger = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_valid", tx_valid, 1);
      reset = 1'b0;
      #1;
      check("midrst_valid", tx_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_data", tx_data, 0);
      exp_q.delete();
      tb_seq = 8'h00;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_frame(48'h0003_0002_0001, 1'b0, 0);

      p_enable = 1'b1;
      period_window(160, 50, nr, nd);
      check("p_starts", nr, 3);
      total_done = nd;
      p_enable = 1'b0;
      period_window(120, 50, nr, nd);
      check("p_disabled", nr, 0);
      total_done += nd;
      check("p_done", total_done, 3);
      p_enable = 1'b1;
      period_window(60, 50, nr, nd);
      check("p_restart", nr, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
